nibble_serial_addsub_ctrl: RTL and testbench

- Sequencer that performs WIDTH-bit add/subtract by time-sharing one 4-bit adder-cum-subtractor datapath, one nibble per clock, LSB nibble first.
- Holds a carry register between nibbles.
- Accepts operands over a valid/ready handshake and presents a registered result over a second valid/ready handshake.
- Sits between an operand source (register file or CPU-style issue logic) and a result consumer; trades latency for area.

---
 rtl/nibble_serial_addsub_ctrl_pkg.sv | 13 +
 rtl/full_adder.sv | 14 +
 rtl/nibble_serial_addsub_ctrl_nibble_addsub.sv | 31 +++
 rtl/nibble_serial_addsub_ctrl.sv | 130 +++++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared types for the nibble-serial add/sub sequencer.
// Holds the FSM state encoding and the datapath slice width.
package nibble_serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Ports: a, b, ci in; s (sum), co (carry out) out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/nibble_serial_addsub_ctrl_nibble_addsub.sv
// Combinational 4-bit ripple adder built from full_adder cells.
// Ports: a, b (pre-conditioned), cin in; sum, c3 (carry into bit 3), cout out.
module nibble_addsub
  import nibble_serial_addsub_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             c3,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign c3   = c[NIB_W-1];
  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// WIDTH-bit add/subtract sequenced one nibble per clock, LSB first.
// Ports: clk, rst; in_valid/in_ready, op_a, op_b, sub; out_valid/out_ready, result, cout_or_borrow, overflow.
module nibble_serial_addsub_ctrl
  import nibble_serial_addsub_ctrl_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout_or_borrow,
  output logic             overflow
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and at least 4");
  end

  state_t state, next;

  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             sub_q, carry, cob_q, ovf_q;
  logic [IW-1:0]    idx;

  logic [NIB_W-1:0] a_nib, b_raw, b_nib, sum;
  logic             c3, cout, last, accept;

  assign last   = (idx == IW'(NIB - 1));
  assign accept = in_valid && in_ready;

  always_comb begin
    a_nib = '0;
    b_raw = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_raw = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  // Subtract is a + ~b + 1: invert b here, the +1 enters as the initial carry.
  assign b_nib = b_raw ^ {NIB_W{sub_q}};

  nibble_addsub u_nib (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (sum),
    .c3   (c3),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next      = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next = RUN;
      end
      RUN: begin
        if (last) next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      res_q <= '0;
      cob_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= op_a;
            b_q   <= op_b;
            sub_q <= sub;
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) res_q[i*NIB_W +: NIB_W] <= sum;
          end
          carry <= cout;
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            cob_q <= cout;
            ovf_q <= c3 ^ cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign result         = res_q;
  assign cout_or_borrow = cob_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Scoreboard bench for nibble_serial_addsub_ctrl (WIDTH=16).
// Stimulus pushes expected results; a monitor pops on each output handshake.
module tb_nibble_serial_addsub_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         in_ready, out_valid, cob, ovf;
  logic [W-1:0] result;

  nibble_serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .op_a           (op_a),
    .op_b           (op_b),
    .sub            (sub),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .cout_or_borrow (cob),
    .overflow       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         cob;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Monitor: latency on each rising out_valid, data on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) chk("valid_without_request", sb.size(), 1);
      else chk("latency", cyc - sb[0].acc, W / 4 + 1);
    end
    if (out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      chk("result", result, e.res);
      chk("cout_or_borrow", cob, e.cob);
      chk("overflow", ovf, e.ovf);
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic [W-1:0] er,
                      input logic ec, input logic eo, input bit track);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub = s;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else if (track) sb.push_back('{er, ec, eo, cyc});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_cob", cob, 0);
    chk("rst_ovf", ovf, 0);

    send(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1);
    send(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
    send(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
    send(16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b1, 1'b0, 1);
    drain();

    // Backpressure with a stray request while results are held.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_wait_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 16'h8000);
      chk("bp_in_ready", in_ready, 0);
      if (i == 3) begin
        in_valid = 1'b1;
        op_a = 16'h1111;
        op_b = 16'h1111;
        sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("bp_cob", cob, 0);
    chk("bp_ovf", ovf, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    repeat (10) @(negedge clk);
    chk("no_stray_accept", out_valid, 0);

    // Reset during the second RUN cycle.
    send(16'h0005, 16'h0006, 1'b0, 16'h000B, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    send(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
